spi_scheduler: RTL

SPI_SCHEDULER -- requirements
Module: spi_scheduler

---
 rtl/spi_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/spi_scheduler.sv
// spi_scheduler: round-robin arbiter that lets several requesters share one
// SPI master. A winner's word, slave-select and sync edge are latched in IDLE,
// loaded into the master in LOAD, shifted for word_width cycles in SHIFT, and
// the received word is returned with a one-cycle ACK in DONE.
//
// Handshake: a requester raises REQ[i] with REQ_D/REQ_SSV/REQ_SE valid and
// holds REQ[i] until it sees ACK[i]; ACK[i] is high for exactly one cycle and
// RSP_D carries the received word during that cycle and holds it afterwards.
module spi_scheduler #(
  parameter int word_width = 8,
  parameter int SS_width   = 2,
  parameter int req_count  = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [req_count-1:0]             REQ,
  input  logic [req_count*word_width-1:0]  REQ_D,
  input  logic [req_count*SS_width-1:0]    REQ_SSV,
  input  logic [req_count-1:0]             REQ_SE,
  output logic [req_count-1:0]             GNT,
  output logic [req_count-1:0]             ACK,
  output logic [word_width-1:0]            RSP_D,
  output logic                             BUSY,
  output logic                             SPI_SE,
  output logic                             SPI_WE,
  output logic                             SPI_SSE,
  output logic [SS_width-1:0]              SPI_SSV,
  output logic [word_width-1:0]            SPI_D_IN,
  input  logic [word_width-1:0]            SPI_D_OUT,
  output logic [1:0]                       dbg_state_o
);

  localparam int IW = (req_count > 1) ? $clog2(req_count) : 1;
  localparam int CW = $clog2(word_width + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         win_q, win_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [word_width-1:0] tx_q, tx_d;
  logic [SS_width-1:0]   ssv_q, ssv_d;
  logic                  se_q, se_d;
  logic [word_width-1:0] rsp_q, rsp_d;

  logic                  found;
  logic [IW-1:0]         pick;
  logic [IW:0]           cand;
  logic [IW-1:0]         ptr_nxt;

  // Round-robin pick: first requesting index at or above ptr_q, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < req_count; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(req_count)) cand = cand - (IW+1)'(req_count);
      if (!found && REQ[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  // Pointer moves just past the winner; a single requester keeps it at 0.
  always_comb begin
    if (win_q == IW'(req_count - 1)) ptr_nxt = '0;
    else                             ptr_nxt = win_q + 1'b1;
  end

  // FSM next state and latched transfer context.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    ssv_d   = ssv_q;
    se_d    = se_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          tx_d    = REQ_D[pick*word_width +: word_width];
          ssv_d   = REQ_SSV[pick*SS_width +: SS_width];
          se_d    = REQ_SE[pick];
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = CW'(word_width);
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        rsp_d   = SPI_D_OUT;
        ptr_d   = ptr_nxt;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      ssv_q   <= '0;
      se_q    <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      ssv_q   <= ssv_d;
      se_q    <= se_d;
      rsp_q   <= rsp_d;
    end
  end

  // Grant is one-hot on the winner while busy; ACK is the grant during DONE.
  always_comb begin
    GNT = '0;
    ACK = '0;
    for (int i = 0; i < req_count; i++) begin
      GNT[i] = (state_q != IDLE) && (win_q == IW'(i));
      ACK[i] = (state_q == DONE) && (win_q == IW'(i));
    end
  end

  // SPI master controls decode straight from the registered state so that
  // reset removes them in the same time step.
  always_comb begin
    BUSY     = (state_q != IDLE);
    SPI_WE   = (state_q == LOAD);
    SPI_SSE  = (state_q == SHIFT);
    SPI_SE   = se_q;
    SPI_SSV  = ssv_q;
    SPI_D_IN = tx_q;
    // The received word is passed through during DONE so it is valid with ACK.
    RSP_D    = (state_q == DONE) ? SPI_D_OUT : rsp_q;
  end

  assign dbg_state_o = state_q;

endmodule
